regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read-port register file with a per-register pending
//               (busy) scoreboard. Register 0 is hard-wired to zero and
//               optional write-to-read forwarding is provided.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int  XLEN   = 32,
    parameter int  NREG   = 32,
    parameter int  NRP    = 2,
    parameter int  BYPASS = 1,
    localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                alloc,
    input  logic [AW-1:0]       alloc_addr,
    output logic [NREG-1:0]     busy_vec
);

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic            w_wr_ok;
    logic            w_alloc_ok;

    // A write qualifies only outside reset, to a real non-zero register.
    // Gating with rst_n also suppresses forwarding while reset is held.
    assign w_wr_ok    = rst_n && we && (waddr != '0) && (int'(waddr) < NREG);
    assign w_alloc_ok = alloc && (alloc_addr != '0) && (int'(alloc_addr) < NREG);

    // Data storage: asynchronous clear, commit qualified writes on clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NREG; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Scoreboard: a write retires the producer, an alloc installs a new one.
    // The alloc assignment comes last so a same-index alloc wins over the
    // retiring write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_busy[waddr] <= 1'b0;
            end
            if (w_alloc_ok) begin
                r_busy[alloc_addr] <= 1'b1;
            end
        end
    end

    assign busy_vec = r_busy;

    // Independent combinational read ports.
    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_live;
        logic          w_fwd;

        assign w_ra   = raddr[i*AW +: AW];
        // Register 0, out-of-range indices and reset all read as zero/not busy.
        assign w_live = rst_n && (w_ra != '0) && (int'(w_ra) < NREG);
        assign w_fwd  = (BYPASS != 0) && w_wr_ok && (w_ra == waddr);

        assign rdata[i*XLEN +: XLEN] = !w_live ? '0 :
                                       w_fwd   ? wdata : r_mem[w_ra];
        assign rbusy[i]              = w_live && r_busy[w_ra] && !w_fwd;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Randomised self-checking bench for regfile_mp. Three
//               instances: forwarding on, forwarding off (sharing inputs),
//               and a 20-entry / 3-port variant exercising out-of-range
//               indices.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Shared stimulus for the two 32x2 instances.
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic        alloc = 1'b0;
    logic [4:0]  alloc_addr = '0;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;
    logic [31:0] busy_a, busy_b;

    // Stimulus for the 20x3 instance.
    logic        we2 = 1'b0;
    logic [4:0]  waddr2 = '0;
    logic [31:0] wdata2 = '0;
    logic [14:0] raddr2 = '0;
    logic        alloc2 = 1'b0;
    logic [4:0]  alloc_addr2 = '0;
    logic [95:0] rdata2;
    logic [2:0]  rbusy2;
    logic [19:0] busy2v;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: architectural contents and pending flags.
    logic [31:0] m0 [32];
    bit          b0 [32];
    logic [31:0] m2 [20];
    bit          b2 [20];

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .alloc(alloc), .alloc_addr(alloc_addr), .busy_vec(busy_a));

    regfile_mp #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .alloc(alloc), .alloc_addr(alloc_addr), .busy_vec(busy_b));

    regfile_mp #(.XLEN(32), .NREG(20), .NRP(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .raddr(raddr2), .rdata(rdata2), .rbusy(rbusy2),
        .alloc(alloc2), .alloc_addr(alloc_addr2), .busy_vec(busy2v));

    always #5 clk = ~clk;

    // Reference model update: reset wipes everything; otherwise a legal write
    // stores data and retires the producer, then a legal alloc marks busy.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) begin m0[k] = '0; b0[k] = 0; end
            for (int k = 0; k < 20; k++) begin m2[k] = '0; b2[k] = 0; end
        end else begin
            if (we && waddr != 0) begin m0[waddr] = wdata; b0[waddr] = 0; end
            if (alloc && alloc_addr != 0) b0[alloc_addr] = 1;
            if (we2 && waddr2 != 0 && waddr2 < 20) begin m2[waddr2] = wdata2; b2[waddr2] = 0; end
            if (alloc2 && alloc_addr2 != 0 && alloc_addr2 < 20) b2[alloc_addr2] = 1;
        end
    end

    function automatic logic [31:0] e_rd0(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 0) return 32'd0;
        if (byp && we && waddr == a) return wdata;
        return m0[a];
    endfunction

    function automatic logic e_bz0(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 0) return 1'b0;
        if (byp && we && waddr == a) return 1'b0;
        return b0[a];
    endfunction

    function automatic logic [31:0] e_rd2(input logic [4:0] a);
        if (!rst_n || a == 0 || a >= 20) return 32'd0;
        if (we2 && waddr2 == a) return wdata2;
        return m2[a];
    endfunction

    function automatic logic e_bz2(input logic [4:0] a);
        if (!rst_n || a == 0 || a >= 20) return 1'b0;
        if (we2 && waddr2 == a) return 1'b0;
        return b2[a];
    endfunction

    function automatic logic [31:0] e_bv0();
        logic [31:0] v;
        for (int k = 0; k < 32; k++) v[k] = b0[k];
        return v;
    endfunction

    function automatic logic [19:0] e_bv2();
        logic [19:0] v;
        for (int k = 0; k < 20; k++) v[k] = b2[k];
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; alloc = 0; we2 = 0; alloc2 = 0;
    endtask

    // Reset holds everything at zero regardless of write/alloc activity,
    // then every index reads zero once reset is released.
    task automatic test_reset();
        logic [4:0] a;
        rst_n = 0;
        we = 1; waddr = 5; wdata = $urandom; alloc = 1; alloc_addr = 6;
        we2 = 1; waddr2 = 3; wdata2 = $urandom; alloc2 = 1; alloc_addr2 = 4;
        cyc();
        for (int i = 0; i < 32; i++) begin
            a = i[4:0];
            raddr = {a, a}; raddr2 = {a, a, a}; waddr = a;
            #0.1;
            n_checks++;
            if (rdata_a !== 64'd0 || rdata_b !== 64'd0 || rdata2 !== 96'd0) begin
                n_errors++;
                $display("FAIL reset_rdata idx=%0d got a=%h b=%h c=%h want 0", i, rdata_a, rdata_b, rdata2);
            end
        end
        cyc();
        n_checks++;
        if (busy_a !== 0 || busy_b !== 0 || busy2v !== 0 || rbusy_a !== 0 || rbusy2 !== 0) begin
            n_errors++;
            $display("FAIL reset_busy got a=%h b=%h c=%h want 0", busy_a, busy_b, busy2v);
        end
        idle();
        #2 rst_n = 1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            a = i[4:0];
            raddr = {a, a}; raddr2 = {a, a, a};
            #0.1;
            n_checks++;
            if (rdata_a !== 64'd0 || rdata_b !== 64'd0 || rdata2 !== 96'd0 || rbusy_a !== 0 || rbusy_b !== 0) begin
                n_errors++;
                $display("FAIL post_reset_read idx=%0d got a=%h b=%h c=%h want 0", i, rdata_a, rdata_b, rdata2);
            end
        end
        // First write after release commits on the first edge.
        cyc();
        rst_n = 0;
        #1;
        we = 1; waddr = 12; wdata = 32'hCAFE_0012;
        #1 rst_n = 1;
        cyc();
        idle(); raddr = {5'd0, 5'd12};
        #0.1;
        n_checks++;
        if (rdata_b[31:0] !== 32'hCAFE_0012) begin
            n_errors++;
            $display("FAIL first_write_after_reset got %h want cafe0012", rdata_b[31:0]);
        end
    endtask

    task automatic test_basic();
        we = 1; waddr = 5; wdata = 32'hDEADBEEF;
        cyc();
        idle(); raddr = {5'd5, 5'd5};
        #0.1;
        n_checks++;
        if (rdata_a !== {2{32'hDEADBEEF}} || rdata_b !== {2{32'hDEADBEEF}}) begin
            n_errors++;
            $display("FAIL dual_port_r5 got a=%h b=%h want deadbeef x2", rdata_a, rdata_b);
        end
        we = 1; waddr = 0; wdata = 32'h1234; raddr = {5'd0, 5'd0};
        #0.1;
        n_checks++;
        if (rdata_a !== 64'd0) begin
            n_errors++;
            $display("FAIL r0_bypass got %h want 0", rdata_a);
        end
        cyc();
        idle();
        #0.1;
        n_checks++;
        if (rdata_a !== 64'd0 || rdata_b !== 64'd0 || busy_a[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL r0_write got a=%h b=%h want 0", rdata_a, rdata_b);
        end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 7; wdata = 32'h11;
        cyc();
        we = 1; waddr = 7; wdata = 32'h22; raddr = {5'd7, 5'd7};
        #0.1;
        n_checks++;
        if (rdata_a[31:0] !== 32'h22 || rdata_b[31:0] !== 32'h11) begin
            n_errors++;
            $display("FAIL bypass_same_cycle got fwd=%h nofwd=%h want 22/11", rdata_a[31:0], rdata_b[31:0]);
        end
        cyc();
        idle();
        #0.1;
        n_checks++;
        if (rdata_b[63:32] !== 32'h22 || rdata_a[63:32] !== 32'h22) begin
            n_errors++;
            $display("FAIL bypass_next_cycle got fwd=%h nofwd=%h want 22", rdata_a[63:32], rdata_b[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        alloc = 1; alloc_addr = 3;
        cyc();
        idle(); raddr = {5'd3, 5'd1};
        #0.1;
        n_checks++;
        if (busy_a[3] !== 1'b1 || rbusy_a !== 2'b10 || rbusy_b !== 2'b10) begin
            n_errors++;
            $display("FAIL alloc_busy got bv=%h rb=%b want bit3 rb=10", busy_a, rbusy_a);
        end
        // Retiring write forwards and masks busy only with forwarding on.
        we = 1; waddr = 3; wdata = 32'hAA;
        #0.1;
        n_checks++;
        if (rbusy_a !== 2'b00 || rbusy_b !== 2'b10 || rdata_a[63:32] !== 32'hAA) begin
            n_errors++;
            $display("FAIL retire_fwd got rba=%b rbb=%b d=%h want 00/10/aa", rbusy_a, rbusy_b, rdata_a[63:32]);
        end
        cyc();
        idle();
        #0.1;
        n_checks++;
        if (busy_a[3] !== 1'b0 || rbusy_b !== 2'b00 || rdata_b[63:32] !== 32'hAA) begin
            n_errors++;
            $display("FAIL retire got bv=%h d=%h want clear/aa", busy_a, rdata_b[63:32]);
        end
        // Same-index alloc and write: data lands, busy stays; second alloc also.
        alloc = 1; alloc_addr = 3; we = 1; waddr = 3; wdata = 32'hBB;
        cyc();
        alloc = 1; alloc_addr = 3; we = 1; waddr = 9; wdata = 32'h99;
        cyc();
        idle(); raddr = {5'd3, 5'd9};
        #0.1;
        n_checks++;
        if (busy_a[3] !== 1'b1 || busy_a[9] !== 1'b0 || rdata_b !== {32'hBB, 32'h99} || rbusy_b !== 2'b10) begin
            n_errors++;
            $display("FAIL alloc_write_same got bv=%h d=%h want bit3 bb/99", busy_a, rdata_b);
        end
        alloc = 1; alloc_addr = 10; we = 1; waddr = 3; wdata = 32'hCC;
        cyc();
        idle();
        #0.1;
        n_checks++;
        if (busy_a[3] !== 1'b0 || busy_a[10] !== 1'b1 || rdata_b[63:32] !== 32'hCC) begin
            n_errors++;
            $display("FAIL alloc_write_diff got bv=%h d=%h want bit10 cc", busy_a, rdata_b[63:32]);
        end
    endtask

    task automatic test_range();
        for (int i = 1; i < 4; i++) begin
            we2 = 1; waddr2 = i[4:0]; wdata2 = 32'h100 * i + 32'h7;
            cyc();
        end
        we2 = 1; waddr2 = 20; wdata2 = 32'hBAD0_0020; alloc2 = 1; alloc_addr2 = 20;
        raddr2 = {5'd20, 5'd20, 5'd20};
        #0.1;
        n_checks++;
        if (rdata2 !== 96'd0 || rbusy2 !== 3'd0) begin
            n_errors++;
            $display("FAIL oor_bypass got %h want 0", rdata2);
        end
        cyc();
        idle();
        #0.1;
        n_checks++;
        if (rdata2 !== 96'd0 || busy2v !== 20'd0) begin
            n_errors++;
            $display("FAIL oor_write got d=%h bv=%h want 0", rdata2, busy2v);
        end
        raddr2 = {5'd3, 5'd2, 5'd1};
        #0.1;
        n_checks++;
        if (rdata2 !== {32'h307, 32'h207, 32'h107}) begin
            n_errors++;
            $display("FAIL three_ports got %h want 307/207/107", rdata2);
        end
    endtask

    // Reset asserted between clock edges clears state with no edge at all.
    task automatic test_async_reset();
        logic [4:0] a;
        for (int i = 1; i < 32; i++) begin
            we = 1; waddr = i[4:0]; wdata = 32'h1000_0000 + 32'h111 * i;
            alloc = (i == 31); alloc_addr = 4;
            we2 = (i < 20); waddr2 = i[4:0]; wdata2 = 32'h2000_0000 + i;
            alloc2 = (i == 19); alloc_addr2 = 6;
            cyc();
        end
        we = 1; waddr = 9; wdata = 32'hFFFF_0009; alloc = 1; alloc_addr = 11;
        we2 = 0; alloc2 = 0;
        raddr = {5'd4, 5'd4};
        #0.1;
        n_checks++;
        if (busy_a[4] !== 1'b1 || busy2v[6] !== 1'b1 || rdata_b[31:0] !== 32'h1000_0444) begin
            n_errors++;
            $display("FAIL preload got bv=%h d=%h want bit4 10000444", busy_a, rdata_b[31:0]);
        end
        #2 rst_n = 0;
        #0.5;
        n_checks++;
        if (busy_a !== 0 || busy_b !== 0 || busy2v !== 0 || rdata_a !== 0 || rdata_b !== 0) begin
            n_errors++;
            $display("FAIL async_clear got bva=%h bvc=%h d=%h want 0", busy_a, busy2v, rdata_a);
        end
        #0.5 rst_n = 1;
        idle();
        for (int i = 0; i < 32; i++) begin
            a = i[4:0];
            raddr = {a, a}; raddr2 = {a, a, a};
            #0.1;
            n_checks++;
            if (rdata_a !== 0 || rdata_b !== 0 || rdata2 !== 0) begin
                n_errors++;
                $display("FAIL async_data idx=%0d got a=%h c=%h want 0", i, rdata_a, rdata2);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] ra;
        for (int c = 0; c < 400; c++) begin
            we = ($urandom_range(0, 2) != 0); waddr = 5'($urandom); wdata = $urandom;
            alloc = ($urandom_range(0, 2) == 0); alloc_addr = 5'($urandom);
            raddr = 10'($urandom);
            if ($urandom_range(0, 3) == 0) raddr[4:0] = waddr;
            if ($urandom_range(0, 5) == 0) alloc_addr = waddr;
            we2 = ($urandom_range(0, 2) != 0); waddr2 = 5'($urandom); wdata2 = $urandom;
            alloc2 = ($urandom_range(0, 2) == 0); alloc_addr2 = 5'($urandom);
            raddr2 = 15'($urandom);
            if ($urandom_range(0, 3) == 0) raddr2[9:5] = waddr2;
            #1;
            for (int p = 0; p < 2; p++) begin
                ra = raddr[p*5 +: 5];
                n_checks++;
                if (rdata_a[p*32 +: 32] !== e_rd0(ra, 1) || rdata_b[p*32 +: 32] !== e_rd0(ra, 0) ||
                    rbusy_a[p] !== e_bz0(ra, 1) || rbusy_b[p] !== e_bz0(ra, 0)) begin
                    n_errors++;
                    $display("FAIL rand_port cyc=%0d p=%0d a=%0d got %h/%h rb=%b/%b want %h/%h rb=%b/%b",
                             c, p, ra, rdata_a[p*32 +: 32], rdata_b[p*32 +: 32], rbusy_a[p], rbusy_b[p],
                             e_rd0(ra, 1), e_rd0(ra, 0), e_bz0(ra, 1), e_bz0(ra, 0));
                end
            end
            for (int p = 0; p < 3; p++) begin
                ra = raddr2[p*5 +: 5];
                n_checks++;
                if (rdata2[p*32 +: 32] !== e_rd2(ra) || rbusy2[p] !== e_bz2(ra)) begin
                    n_errors++;
                    $display("FAIL rand_port20 cyc=%0d p=%0d a=%0d got %h rb=%b want %h rb=%b",
                             c, p, ra, rdata2[p*32 +: 32], rbusy2[p], e_rd2(ra), e_bz2(ra));
                end
            end
            n_checks++;
            if (busy_a !== e_bv0() || busy_b !== e_bv0() || busy2v !== e_bv2()) begin
                n_errors++;
                $display("FAIL rand_busy_vec cyc=%0d got %h/%h/%h want %h/%h",
                         c, busy_a, busy_b, busy2v, e_bv0(), e_bv2());
            end
            cyc();
        end
        idle();
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin m0[k] = '0; b0[k] = 0; end
        for (int k = 0; k < 20; k++) begin m2[k] = '0; b2[k] = 0; end
        #1;
        test_reset();
        test_basic();
        test_bypass();
        test_scoreboard();
        test_range();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
